// File: rtl/sound_scheduler_pkg.sv
// Shared constants for the sound scheduler: note tables, sound ids and the
// fixed-priority pick helper.
package sound_pkg;

  localparam int NUM_SRC = 4;
  localparam int NOTES   = 4;
  localparam int ID_W    = 2;
  localparam int IDX_W   = 2;

  typedef enum logic [ID_W-1:0] {
    SND_JUMP  = 2'd0,
    SND_HOME  = 2'd1,
    SND_LEVEL = 2'd2,
    SND_DEATH = 2'd3
  } snd_id_t;

  // Half-periods and durations in 25.175 MHz cycles; a zero duration ends the sound.
  localparam int unsigned NOTE_HALF [NUM_SRC][NOTES] = '{
    '{28523,     0,     0,     0},
    '{28523, 21362,     0,     0},
    '{47801, 37972, 31928, 23900},
    '{37972, 47801, 63776,     0}
  };

  localparam int unsigned NOTE_DUR [NUM_SRC][NOTES] = '{
    '{12500000,       0,       0,       0},
    '{ 2000000, 4000000,       0,       0},
    '{ 2500000, 2500000, 2500000, 2500000},
    '{ 3000000, 3000000, 6000000,       0}
  };

  function automatic logic [ID_W-1:0] highest_set(input logic [NUM_SRC-1:0] v);
    highest_set = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v[i]) highest_set = ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/sound_scheduler_if.sv
// Request/status bundle between the game-logic FSM and the sound scheduler.
interface sound_scheduler_if;
  import sound_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic               mute;
  logic               audio_out;
  logic               busy;
  logic [ID_W-1:0]    active_id;

  modport master (output req, mute, input audio_out, busy, active_id);
  modport slave  (input req, mute, output audio_out, busy, active_id);

endinterface

// File: rtl/sound_scheduler_tone_gen.sv
// One square-wave note: phase counter, duration counter and output level.
// A load restarts the note; a zero half-period plays a rest.
module tone_gen #(
  parameter int PHASE_W = 17,
  parameter int DUR_W   = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] half_i,
  input  logic [DUR_W-1:0]   dur_i,
  output logic               level_o,
  output logic               note_done_o
);

  logic [PHASE_W-1:0] half_q, phase_q;
  logic [DUR_W-1:0]   dur_q, dcnt_q;
  logic               level_q;

  assign level_o     = level_q;
  assign note_done_o = en_i && (dcnt_q == dur_q - DUR_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      half_q  <= '0;
      dur_q   <= '0;
      phase_q <= '0;
      dcnt_q  <= '0;
      level_q <= 1'b0;
    end else if (load_i) begin
      half_q  <= half_i;
      dur_q   <= dur_i;
      phase_q <= '0;
      dcnt_q  <= '0;
      level_q <= (half_i != '0);
    end else if (en_i) begin
      dcnt_q <= dcnt_q + DUR_W'(1);
      if (half_q == '0) begin
        level_q <= 1'b0;
      end else if (phase_q == half_q - PHASE_W'(1)) begin
        phase_q <= '0;
        level_q <= ~level_q;
      end else begin
        phase_q <= phase_q + PHASE_W'(1);
      end
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// Shares the audio pin between game sound events: edge-latches requests,
// picks the highest pending source and steps through its note table.
//
// state | meaning
// IDLE  | silent, waiting for a pending request
// PLAY  | tone_gen running the current note of active_id
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int PHASE_W    = 17,
  parameter int DUR_W      = 24,
  parameter int TIME_SHIFT = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  sound_scheduler_if.slave bus
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] req_q, pending_q, pending_d, edges, clr;
  logic [ID_W-1:0]    active_id_q, hi, ld_id;
  logic [IDX_W-1:0]   note_idx_q, nxt_idx, ld_idx;
  logic               take, load, finish, last_note, note_done, level, playing;
  logic               audio_q, busy_q;
  logic [PHASE_W-1:0] ld_half;
  logic [DUR_W-1:0]   ld_dur;

  assign playing = (state_q == PLAY);

  always_comb begin
    edges     = bus.req & ~req_q;
    hi        = highest_set(pending_q);
    nxt_idx   = note_idx_q + IDX_W'(1);
    last_note = (note_idx_q == IDX_W'(NOTES - 1)) || (NOTE_DUR[active_id_q][nxt_idx] == 0);
    take      = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    ld_id     = active_id_q;
    ld_idx    = '0;
    // Equal priority in PLAY is a retrigger of the active sound.
    if (|pending_q && (!playing || hi >= active_id_q)) begin
      take  = 1'b1;
      load  = 1'b1;
      ld_id = hi;
    end else if (note_done) begin
      if (last_note) begin
        finish = 1'b1;
      end else begin
        load   = 1'b1;
        ld_idx = nxt_idx;
      end
    end
    clr = '0;
    if (take) clr[ld_id] = 1'b1;
    pending_d = (pending_q & ~clr) | edges;
    ld_half   = PHASE_W'(NOTE_HALF[ld_id][ld_idx] >> TIME_SHIFT);
    ld_dur    = DUR_W'(NOTE_DUR[ld_id][ld_idx] >> TIME_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      active_id_q <= '0;
      note_idx_q  <= '0;
      audio_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_q     <= bus.req;
      pending_q <= pending_d;
      busy_q    <= playing;
      audio_q   <= level & playing & ~bus.mute;
      if (load) begin
        state_q     <= PLAY;
        active_id_q <= ld_id;
        note_idx_q  <= ld_idx;
      end else if (finish) begin
        state_q <= IDLE;
      end
    end
  end

  tone_gen #(.PHASE_W(PHASE_W), .DUR_W(DUR_W)) u_tone (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .en_i       (playing),
    .half_i     (ld_half),
    .dur_i      (ld_dur),
    .level_o    (level),
    .note_done_o(note_done)
  );

  assign bus.audio_out = audio_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = active_id_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler with TIME_SHIFT=11 to keep runs short.
// Shifted table: jump 13/6103, death 18/1464 23/1464 31/2929, level 23,18,15,11 /1220.
module tb_sound_scheduler;
  import sound_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  sound_scheduler_if bus ();

  sound_scheduler #(.TIME_SHIFT(11)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.req  = '0;
    bus.mute = 1'b0;
    reset_n  = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    bus.req  = '0;
    bus.mute = 1'b0;
    tick(2);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL reset_audio: got %b exp 0", bus.audio_out); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.active_id !== 2'd0) $display("FAIL reset_active_id: got %0d exp 0", bus.active_id); else n_pass++;
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_jump_basic();
    do_reset();
    bus.req = 4'b0001; tick(1);
    bus.req = 4'b0000; tick(1);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL jump_busy_latency: got %b exp 0", bus.busy); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL jump_busy_on: got %b exp 1", bus.busy); else n_pass++;
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL jump_audio_first: got %b exp 1", bus.audio_out); else n_pass++;
    n_checks++; if (bus.active_id !== SND_JUMP) $display("FAIL jump_active_id: got %0d exp 0", bus.active_id); else n_pass++;
    tick(12);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL jump_high_end: got %b exp 1", bus.audio_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL jump_low_start: got %b exp 0", bus.audio_out); else n_pass++;
    tick(12);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL jump_low_end: got %b exp 0", bus.audio_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL jump_high_again: got %b exp 1", bus.audio_out); else n_pass++;
    tick(6076);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL jump_busy_last: got %b exp 1", bus.busy); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL jump_busy_off: got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL jump_audio_off: got %b exp 0", bus.audio_out); else n_pass++;
  endtask

  task automatic test_death_preempts();
    do_reset();
    bus.req = 4'b0001; tick(1);
    bus.req = 4'b0000; tick(1000);
    bus.req = 4'b1000; tick(1);
    bus.req = 4'b0000;
    n_checks++; if (bus.active_id !== SND_JUMP) $display("FAIL preempt_id_before: got %0d exp 0", bus.active_id); else n_pass++;
    tick(1);
    n_checks++; if (bus.active_id !== SND_DEATH) $display("FAIL preempt_id: got %0d exp 3", bus.active_id); else n_pass++;
    tick(1);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL preempt_audio_first: got %b exp 1", bus.audio_out); else n_pass++;
    tick(17);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL preempt_high_end: got %b exp 1", bus.audio_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL preempt_half18: got %b exp 0", bus.audio_out); else n_pass++;
    tick(5838);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL death_busy_last: got %b exp 1", bus.busy); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL death_busy_off: got %b exp 0", bus.busy); else n_pass++;
    tick(50);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL jump_not_resumed: got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.active_id !== SND_DEATH) $display("FAIL last_id_kept: got %0d exp 3", bus.active_id); else n_pass++;
  endtask

  task automatic test_queued_lower();
    do_reset();
    bus.req = 4'b1000; tick(1);
    bus.req = 4'b0000; tick(100);
    bus.req = 4'b0001; tick(1);
    bus.req = 4'b0000; tick(1);
    n_checks++; if (bus.active_id !== SND_DEATH) $display("FAIL queued_no_preempt: got %0d exp 3", bus.active_id); else n_pass++;
    tick(5756);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL queued_death_last: got %b exp 1", bus.busy); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL queued_idle_gap: got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.active_id !== SND_JUMP) $display("FAIL queued_id: got %0d exp 0", bus.active_id); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL queued_busy_on: got %b exp 1", bus.busy); else n_pass++;
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL queued_audio_on: got %b exp 1", bus.audio_out); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.req = 4'b0101; tick(1);
    bus.req = 4'b0000; tick(1);
    n_checks++; if (bus.active_id !== SND_LEVEL) $display("FAIL simul_first_id: got %0d exp 2", bus.active_id); else n_pass++;
    tick(1);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL simul_audio_first: got %b exp 1", bus.audio_out); else n_pass++;
    tick(1219);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL level_note0_tail: got %b exp 0", bus.audio_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL level_note1_start: got %b exp 1", bus.audio_out); else n_pass++;
    tick(17);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL level_note1_high: got %b exp 1", bus.audio_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL level_note1_low: got %b exp 0", bus.audio_out); else n_pass++;
    tick(3641);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL level_busy_last: got %b exp 1", bus.busy); else n_pass++;
    n_checks++; if (bus.active_id !== SND_LEVEL) $display("FAIL level_id_last: got %0d exp 2", bus.active_id); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL simul_gap: got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.active_id !== SND_JUMP) $display("FAIL simul_second_id: got %0d exp 0", bus.active_id); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL simul_second_busy: got %b exp 1", bus.busy); else n_pass++;
  endtask

  task automatic test_retrigger_hold();
    do_reset();
    bus.req = 4'b0001; tick(3);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL hold_busy_on: got %b exp 1", bus.busy); else n_pass++;
    tick(6102);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL hold_busy_last: got %b exp 1", bus.busy); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL hold_busy_off: got %b exp 0", bus.busy); else n_pass++;
    tick(1895);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL hold_no_retrigger: got %b exp 0", bus.busy); else n_pass++;
    bus.req = 4'b0000; tick(5);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL hold_release: got %b exp 0", bus.busy); else n_pass++;
    bus.req = 4'b0001; tick(1);
    bus.req = 4'b0000; tick(15);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL retrig_pre_low: got %b exp 0", bus.audio_out); else n_pass++;
    bus.req = 4'b0001; tick(1);
    bus.req = 4'b0000; tick(1);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL retrig_latency: got %b exp 0", bus.audio_out); else n_pass++;
    tick(1);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL retrig_note0: got %b exp 1", bus.audio_out); else n_pass++;
    tick(6102);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL retrig_busy_last: got %b exp 1", bus.busy); else n_pass++;
    tick(1);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL retrig_busy_off: got %b exp 0", bus.busy); else n_pass++;
    tick(5);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL retrig_no_pending: got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_mute_reset();
    do_reset();
    bus.req = 4'b1000; tick(1);
    bus.req = 4'b0000; tick(2);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL mute_pre_audio: got %b exp 1", bus.audio_out); else n_pass++;
    bus.mute = 1'b1; tick(1);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL mute_audio: got %b exp 0", bus.audio_out); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL mute_busy: got %b exp 1", bus.busy); else n_pass++;
    bus.mute = 1'b0; tick(1);
    n_checks++; if (bus.audio_out !== 1'b1) $display("FAIL unmute_audio: got %b exp 1", bus.audio_out); else n_pass++;
    n_checks++; if (bus.active_id !== SND_DEATH) $display("FAIL mute_id: got %0d exp 3", bus.active_id); else n_pass++;
    reset_n = 1'b0; tick(1);
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL midreset_audio: got %b exp 0", bus.audio_out); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.active_id !== 2'd0) $display("FAIL midreset_id: got %0d exp 0", bus.active_id); else n_pass++;
    reset_n = 1'b1; tick(20);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL post_reset_silent: got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.audio_out !== 1'b0) $display("FAIL post_reset_audio: got %b exp 0", bus.audio_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_jump_basic();
    test_death_preempts();
    test_queued_lower();
    test_simultaneous();
    test_retrigger_hold();
    test_mute_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Shares the single square-wave audio pin between the game's sound events: jump, frog home, level clear, and death. Each event source pulses or holds a request line. The block latches rising edges, arbitrates by fixed priority, and plays the chosen sound as a sequence of up to four tones read from a constant note table. It sits between the game-logic FSM and the audio output pin and replaces the per-sound tone generators.

## Interface
- `NUM_SRC`, 4: number of request sources. The index is also the priority; a higher index wins.
- `NOTES`, 4: maximum tones per sound.
- `PHASE_W`, 17: half-period counter width, in clock cycles.
- `DUR_W`, 24: tone-duration counter width, in clock cycles.
- `TIME_SHIFT`, 0: right-shift applied to every table half-period and duration. Use it only to shorten simulation.
- `clk` in 1: 25.175 MHz pixel clock.
- `reset_n` in 1: synchronous, active-low reset.
- `req` in NUM_SRC: sound requests, level or pulse. Source 0 is jump, 1 is home, 2 is level clear, 3 is death.
- `mute` in 1: forces `audio_out` low. Sequencing continues.
- `audio_out` out 1: registered square wave.
- `busy` out 1: high while a sound is playing.
- `active_id` out 2: index of the sound playing, or of the last one played. It is 0 after reset.

## Operation
- **Edge detection.** `req_q` is the registered copy of `req`. A rising edge (`req[i] & ~req_q[i]`) sets `pending[i]`. A held request never retriggers.
- **States.** The FSM has two states, IDLE and PLAY.
- **IDLE.**
  - If `pending` is nonzero, select its highest set bit `s`.
  - Clear `pending[s]` and set `active_id` to `s`.
  - Set the note index to 0, load the note-0 half-period and duration, clear the phase and duration counters, and go to PLAY.
- **PLAY.**
  - Each cycle the phase counter runs from 0 to half−1. At half−1 it wraps to 0 and the square level toggles. The level starts at 1 for each note.
  - The duration counter runs from 0 to dur−1. At dur−1 the block advances to the next note and resets the phase counter and level.
  - The sound finishes when the note index is NOTES−1 or when the next note's duration is 0. It then returns to IDLE.
- **Rests.** A note with half-period 0 is a rest: the level is held at 0 for the note's duration.
- **Preemption.** If, during PLAY, some `pending[j]` is set with j > `active_id`, the block restarts the load sequence on `j` on the next cycle. The interrupted sound is dropped, not resumed.
- **Retrigger of the active sound.** A rising edge on `req[active_id]` during PLAY restarts that sound from note 0 on the next cycle. It does not leave a pending bit.
- **Lower priority.** A rising edge on `req[j]` with j < `active_id` stays pending and plays after the current sound finishes.
- **Same-cycle edges.** If several edges arrive in the same cycle, all set their pending bits, and the highest is served first.
- **Output.** `audio_out` is the square level AND `busy` AND NOT `mute`, registered.
- **Reset.** `reset_n` low at any edge, including mid-sound, does the following:
  - returns the FSM to IDLE;
  - clears `pending`, `req_q` and all counters;
  - sets `audio_out`, `busy` and `active_id` to 0.
- **Overflow.** Table values must fit PHASE_W and DUR_W; the counters never exceed them.

## Timing
- `req[i]` first sampled high at edge E0 sets `pending` at E0.
- The FSM enters PLAY at E1.
- `busy` is 1 and `audio_out` is 1 after E2. Request-to-sound latency is 2 cycles.
- A note with half-period H produces H cycles high, then H cycles low, repeating. Its duration D is exactly D cycles, independent of phase.
- The final note ends at cycle D; the FSM is back in IDLE one edge later, and `busy` falls on the following edge.
- A pending sound queued behind the final note starts on the next IDLE cycle, so there is a gap of 1 idle cycle.
- Preemption and retrigger take effect 1 cycle after the edge is latched. `audio_out` goes to 1, as the new note 0, 2 cycles after that latch.

## Structure
- Package `sound_pkg` holds the `NOTE_HALF[NUM_SRC][NOTES]` and `NOTE_DUR[NUM_SRC][NOTES]` constant arrays, plus the `snd_id_t` enum (SND_JUMP=0, SND_HOME=1, SND_LEVEL=2, SND_DEATH=3). The table contents are:
  - Jump: {28523/12500000, 0/0, 0/0, 0/0}.
  - Home: {28523/2000000, 21362/4000000, 0/0, 0/0}.
  - Level: {47801, 37972, 31928, 23900}, each /2500000.
  - Death: {37972/3000000, 47801/3000000, 63776/6000000, 0/0}.
- Sub-module `tone_gen` holds the phase counter, duration counter and square level. It has a load strobe, half and dur inputs, and `level` and `note_done` outputs. The arbiter and FSM stay in `sound_scheduler`.

## Test plan
All scenarios use TIME_SHIFT=8, which makes the jump note half 111, dur 48828.
- **Jump basic.** After reset, pulse `req[0]` for 1 cycle. Expect `audio_out` high for 111 cycles, then low for 111, starting 2 cycles after the pulse. Expect `busy` for 48828 cycles, then `audio_out`=0 and `busy`=0.
- **Death preempts jump.** Fire `req[3]` 1000 cycles into a jump. Expect `active_id`=3 one cycle later, note half 148, and the jump never resumes.
- **Queued lower priority.** Fire `req[0]` during death. Expect `pending[0]` held, and the jump starting one idle cycle after death ends.
- **Simultaneous edges.** Assert `req`=4'b0101 in one cycle. Expect level clear (2) to play first, then jump (0).
- **Retrigger and hold.** Hold `req[0]` high for 100000 cycles. Expect exactly one jump. Then re-pulse mid-jump and expect a restart from note 0.
- **Mute and reset.** Assert `mute` mid-sound: expect `audio_out`=0 while `busy` stays 1. Drop `reset_n` mid-note: expect all outputs 0 on the next edge, and no sound after release without a new edge.
